// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter letting two masters share one single-port word RAM.
// Define DMEM_ARB_LOCK_EN to build the ownership lock with idle-timeout release.
module dmem_arbiter #(
  parameter int DEPTH_WORDS  = 256,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic        p0_lock,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic        p1_lock,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [29:0] LIMIT_WORDS = 30'(DEPTH_WORDS);

  function automatic logic legal_f(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:2] < LIMIT_WORDS);
  endfunction

  logic        ok0_s, ok1_s;
  logic        gnt0_s, gnt1_s, any_gnt_s, sel_s;
  logic        sel_we_s, sel_legal_s;
  logic [31:0] sel_addr_s, sel_wdata_s, rd_capture_s;
  logic        last_q, last_d;
  logic [1:0]  rvalid_q, rvalid_d, err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

`ifdef DMEM_ARB_LOCK_EN
  logic       own_valid_q, own_valid_d, own_port_q, own_port_d;
  logic [7:0] idle_cnt_q, idle_cnt_d, idle_inc_s;
  logic       own_req_s, sel_lock_s;

  assign ok0_s = ~own_valid_q | ~own_port_q;
  assign ok1_s = ~own_valid_q | own_port_q;

  // Ownership follows the lock bit of every grant; an idle owner times out.
  always_comb begin
    own_req_s   = own_port_q ? p1_req : p0_req;
    sel_lock_s  = sel_s ? p1_lock : p0_lock;
    idle_inc_s  = idle_cnt_q + 8'd1;
    own_valid_d = own_valid_q;
    own_port_d  = own_port_q;
    idle_cnt_d  = idle_cnt_q;
    if (any_gnt_s) begin
      own_valid_d = sel_lock_s;
      own_port_d  = sel_s;
      idle_cnt_d  = 8'd0;
    end else if (own_valid_q) begin
      if (own_req_s) begin
        idle_cnt_d = 8'd0;
      end else if (idle_inc_s >= 8'(LOCK_TIMEOUT)) begin
        own_valid_d = 1'b0;
        idle_cnt_d  = 8'd0;
      end else begin
        idle_cnt_d = idle_inc_s;
      end
    end else begin
      idle_cnt_d = 8'd0;
    end
  end

  // Lock state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      own_valid_q <= 1'b0;
      own_port_q  <= 1'b0;
      idle_cnt_q  <= 8'd0;
    end else begin
      own_valid_q <= own_valid_d;
      own_port_q  <= own_port_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = p0_lock ^ p1_lock ^ (LOCK_TIMEOUT == 0);
  assign ok0_s = 1'b1;
  assign ok1_s = 1'b1;
`endif

  // Grant: the port that did not win last time takes a contended slot.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (p0_req && ok0_s && p1_req && ok1_s) begin
      gnt0_s = last_q;
      gnt1_s = ~last_q;
    end else begin
      gnt0_s = p0_req & ok0_s;
      gnt1_s = p1_req & ok1_s;
    end
    any_gnt_s = gnt0_s | gnt1_s;
    sel_s     = gnt1_s;
  end

  // Memory drive from the granted port; illegal accesses never write.
  always_comb begin
    sel_we_s    = sel_s ? p1_we    : p0_we;
    sel_addr_s  = sel_s ? p1_addr  : p0_addr;
    sel_wdata_s = sel_s ? p1_wdata : p0_wdata;
    sel_legal_s = legal_f(sel_addr_s);
    if (any_gnt_s) begin
      mem_we = sel_we_s & sel_legal_s;
      mem_a  = sel_addr_s;
      mem_wd = sel_wdata_s;
    end else begin
      mem_we = 1'b0;
      mem_a  = 32'h0;
      mem_wd = 32'h0;
    end
  end

  // Next response state: only the granted port's data/err change.
  always_comb begin
    rd_capture_s = (sel_legal_s && !sel_we_s) ? mem_rd : 32'h0;
    rvalid_d     = {gnt1_s, gnt0_s};
    last_d       = any_gnt_s ? sel_s : last_q;
    if (gnt0_s) begin
      rdata0_d = rd_capture_s;
      err_d[0] = ~sel_legal_s;
    end else begin
      rdata0_d = rdata0_q;
      err_d[0] = err_q[0];
    end
    if (gnt1_s) begin
      rdata1_d = rd_capture_s;
      err_d[1] = ~sel_legal_s;
    end else begin
      rdata1_d = rdata1_q;
      err_d[1] = err_q[1];
    end
  end

  // Pointer and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= 32'h0;
      rdata1_q <= 32'h0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Responses are masked while reset is high so a pending pulse is dropped.
  assign p0_gnt    = gnt0_s;
  assign p1_gnt    = gnt1_s;
  assign p0_rvalid = rvalid_q[0] & ~reset;
  assign p1_rvalid = rvalid_q[1] & ~reset;
  assign p0_err    = err_q[0] & ~reset;
  assign p1_err    = err_q[1] & ~reset;
  assign p0_rdata  = reset ? 32'h0 : rdata0_q;
  assign p1_rdata  = reset ? 32'h0 : rdata1_q;

endmodule
